vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Runtime-reconfigurable VGA/HDMI raster timing generator; next generation of the fixed-timing controller.
//  Combined H/V counter with registered, aligned sync / enable / index outputs and frame/line start strobes.
//  New timing and sync polarity come in through a valid/ready port, are shadowed, and take effect only at a frame boundary.
//  Sits between the pixel clock domain root and the pixel pipeline / TMDS encoder.
// PARAMETERS
//  CNT_W     12    counter / index / config field width
//  H_ACTIVE  1920  reset-default visible pixels per line
//  H_FP      88    reset-default H front porch
//  H_SW      44    reset-default H sync width
//  H_BP      148   reset-default H back porch
//  V_ACTIVE  1080  reset-default visible lines
//  V_FP      4     reset-default V front porch
//  V_SW      5     reset-default V sync width
//  V_BP      36    reset-default V back porch
//  HS_POL    1     reset-default h_sync active level
//  VS_POL    1     reset-default v_sync active level
// PORTS
//  clk           in   1        pixel clock
//  reset         in   1        asynchronous, active-high
//  cfg_valid     in   1        new timing offered
//  cfg_ready     out  1        shadow register free
//  cfg_h         in   4*CNT_W  {active, fp, sw, bp}, active in MSBs
//  cfg_v         in   4*CNT_W  {active, fp, sw, bp}, active in MSBs
//  cfg_pol       in   2        {hs_pol, vs_pol}
//  cfg_err       out  1        1-cycle pulse: offered config rejected
//  h_sync        out  1        horizontal sync
//  v_sync        out  1        vertical sync
//  x_idx         out  CNT_W    horizontal counter
//  y_idx         out  CNT_W    vertical counter
//  video_enable  out  1        inside active area
//  line_start    out  1        1-cycle pulse at x_idx==0
//  frame_start   out  1        1-cycle pulse at x_idx==0 && y_idx==0
// BEHAVIOUR
//  Totals: h_tot = ha+hfp+hsw+hbp; v_tot likewise. Computed in CNT_W+2 bits.
//  Line layout: active, fp, sync, bp. Frame layout is the same in V.
//  h_cnt counts 0..h_tot-1, then wraps to 0. v_cnt increments on h wrap and wraps after v_tot-1.
//  Outputs are registered and mutually aligned. In the same cycle:
//   - x_idx=h_cnt and y_idx=v_cnt;
//   - video_enable = (h_cnt<ha) && (v_cnt<va);
//   - h_sync = hs_pol when ha+hfp <= h_cnt < ha+hfp+hsw, else ~hs_pol (v_sync likewise on v_cnt).
//  Reset (async):
//   - counters 0; live timing and pol load the parameter defaults; shadow cleared;
//   - outputs: x_idx=y_idx=0, video_enable=0, line_start=frame_start=0, cfg_err=0, cfg_ready=1,
//     h_sync=~HS_POL, v_sync=~VS_POL.
//  After reset deasserts, the first clock edge presents (0,0): frame_start=line_start=video_enable=1.
//  Handshake: capture occurs on cfg_valid && cfg_ready.
//   - Valid capture: the shadow is loaded and cfg_ready=0 from the next cycle.
//   - Rejected capture: any field is 0, or either total >= 2^CNT_W. cfg_err pulses next cycle;
//     there is no capture and cfg_ready stays 1.
//   - cfg_valid while cfg_ready=0 is ignored. No error is raised.
//  Apply point: the last pixel of a frame (h_cnt==h_tot-1 && v_cnt==v_tot-1) with the shadow full.
//   - On the next cycle the new timing and pol are live, counters are (0,0), and frame_start=1.
//   - The shadow empties and cfg_ready=1 that same cycle.
//  Capture on the apply-point cycle itself is not applied at that boundary; it waits for the next frame end.
//  The current frame always completes with old timing. No partial lines/frames; sync outputs never glitch mid-frame.
//  A reset mid-frame or with a config pending discards the shadow and restores the defaults.
// TESTING
//  1 Reset, defaults, run 2 frames:
//    - line period 2200 clk; h_sync high for x=2008..2051;
//    - 1920 enable cycles/line; frame period 2200*1125;
//    - v_sync high for y=1084..1088.
//  2 Mid-frame cfg h={4,1,1,2}, v={3,1,1,1}, pol=11:
//    - cfg_ready drops; the default frame finishes;
//    - then frame_start every 48 clk, line_start every 8 clk, 12 enable cycles per frame.
//  3 Second cfg_valid while pending -> ignored, no cfg_err; the first config is the one applied.
//  4 cfg h_sw=0 -> cfg_err one pulse, cfg_ready stays 1, timing unchanged.
//  5 Reset asserted mid-frame with pending cfg -> outputs at reset values immediately;
//    after release, 1080p defaults and cfg_ready=1.
//  6 cfg_pol=00 applied -> h_sync/v_sync idle high, pulse low at the same counter positions.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Configuration handshake plus raster outputs of vga_timing_gen.
// The slave modport is the generator side; the master modport is the controller / pipeline side.
interface vga_timing_gen_if #(
    parameter int CNT_W = 12
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [4*CNT_W-1:0] cfg_h;
    logic [4*CNT_W-1:0] cfg_v;
    logic [1:0]         cfg_pol;
    logic               cfg_err;

    logic               h_sync;
    logic               v_sync;
    logic [CNT_W-1:0]   x_idx;
    logic [CNT_W-1:0]   y_idx;
    logic               video_enable;
    logic               line_start;
    logic               frame_start;

    modport master (
        output cfg_valid,
        output cfg_h,
        output cfg_v,
        output cfg_pol,
        input  cfg_ready,
        input  cfg_err,
        input  h_sync,
        input  v_sync,
        input  x_idx,
        input  y_idx,
        input  video_enable,
        input  line_start,
        input  frame_start
    );

    modport slave (
        input  cfg_valid,
        input  cfg_h,
        input  cfg_v,
        input  cfg_pol,
        output cfg_ready,
        output cfg_err,
        output h_sync,
        output v_sync,
        output x_idx,
        output y_idx,
        output video_enable,
        output line_start,
        output frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Runtime-reconfigurable raster timing generator with registered, aligned sync/enable/index outputs.
// New timing is shadowed through a valid/ready port and goes live only at a frame boundary.
module vga_timing_gen #(
    parameter int   CNT_W    = 12,
    parameter int   H_ACTIVE = 1920,
    parameter int   H_FP     = 88,
    parameter int   H_SW     = 44,
    parameter int   H_BP     = 148,
    parameter int   V_ACTIVE = 1080,
    parameter int   V_FP     = 4,
    parameter int   V_SW     = 5,
    parameter int   V_BP     = 36,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input logic             clk,
    input logic             reset,
    vga_timing_gen_if.slave vga
);

    localparam int TOT_W = CNT_W + 2;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [TOT_W-1:0] tot_t;

    typedef struct packed {
        cnt_t act;
        cnt_t fp;
        cnt_t sw;
        cnt_t bp;
    } axis_t;

    typedef enum logic {
        SH_EMPTY,
        SH_FULL
    } shadow_e;

    localparam axis_t H_DEF   = {cnt_t'(H_ACTIVE), cnt_t'(H_FP), cnt_t'(H_SW), cnt_t'(H_BP)};
    localparam axis_t V_DEF   = {cnt_t'(V_ACTIVE), cnt_t'(V_FP), cnt_t'(V_SW), cnt_t'(V_BP)};
    localparam tot_t  TOT_LIM = tot_t'(1) << CNT_W;

    function automatic tot_t total(input axis_t a);
        return tot_t'(a.act) + tot_t'(a.fp) + tot_t'(a.sw) + tot_t'(a.bp);
    endfunction

    function automatic logic axis_ok(input axis_t a);
        return (a.act != '0) && (a.fp != '0) && (a.sw != '0) && (a.bp != '0) &&
               (total(a) < TOT_LIM);
    endfunction

    function automatic logic in_sync(input axis_t a, input cnt_t c);
        tot_t sync_start;
        sync_start = tot_t'(a.act) + tot_t'(a.fp);
        return (tot_t'(c) >= sync_start) && (tot_t'(c) < sync_start + tot_t'(a.sw));
    endfunction

    function automatic logic at_last(input axis_t a, input cnt_t c);
        return tot_t'(c) == (total(a) - tot_t'(1));
    endfunction

    axis_t      cfg_h_s;
    axis_t      cfg_v_s;
    logic       cfg_fire;
    logic       cfg_ok;
    logic       h_last;
    logic       v_last;
    logic       apply;

    logic       started_q, started_d;
    cnt_t       h_cnt_q,   h_cnt_d;
    cnt_t       v_cnt_q,   v_cnt_d;
    axis_t      live_h_q,  live_h_d;
    axis_t      live_v_q,  live_v_d;
    logic [1:0] pol_q,     pol_d;
    shadow_e    sh_q,      sh_d;
    axis_t      sh_h_q,    sh_h_d;
    axis_t      sh_v_q,    sh_v_d;
    logic [1:0] sh_pol_q,  sh_pol_d;
    logic       hs_q,      hs_d;
    logic       vs_q,      vs_d;
    logic       ven_q,     ven_d;
    logic       ls_q,      ls_d;
    logic       fs_q,      fs_d;
    logic       err_q,     err_d;

    assign cfg_h_s  = vga.cfg_h;
    assign cfg_v_s  = vga.cfg_v;
    assign cfg_fire = vga.cfg_valid && (sh_q == SH_EMPTY);
    assign cfg_ok   = axis_ok(cfg_h_s) && axis_ok(cfg_v_s);
    assign h_last   = at_last(live_h_q, h_cnt_q);
    assign v_last   = at_last(live_v_q, v_cnt_q);
    assign apply    = started_q && (sh_q == SH_FULL) && h_last && v_last;

    always_comb begin
        started_d = started_q;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        live_h_d  = live_h_q;
        live_v_d  = live_v_q;
        pol_d     = pol_q;
        sh_d      = sh_q;
        sh_h_d    = sh_h_q;
        sh_v_d    = sh_v_q;
        sh_pol_d  = sh_pol_q;

        // The first edge after reset presents (0,0) instead of advancing, so x/y track the counters.
        if (!started_q) begin
            started_d = 1'b1;
        end else if (h_last) begin
            h_cnt_d = '0;
            v_cnt_d = v_last ? '0 : v_cnt_q + cnt_t'(1);
        end else begin
            h_cnt_d = h_cnt_q + cnt_t'(1);
        end

        case (sh_q)
            SH_EMPTY: begin
                if (cfg_fire && cfg_ok) begin
                    sh_d     = SH_FULL;
                    sh_h_d   = cfg_h_s;
                    sh_v_d   = cfg_v_s;
                    sh_pol_d = vga.cfg_pol;
                end
            end
            SH_FULL: begin
                if (apply) begin
                    sh_d     = SH_EMPTY;
                    live_h_d = sh_h_q;
                    live_v_d = sh_v_q;
                    pol_d    = sh_pol_q;
                end
            end
            default: sh_d = SH_EMPTY;
        endcase

        // Outputs are derived from next-state values so they stay aligned with x_idx/y_idx.
        err_d = cfg_fire && !cfg_ok;
        ven_d = (h_cnt_d < live_h_d.act) && (v_cnt_d < live_v_d.act);
        ls_d  = (h_cnt_d == '0);
        fs_d  = (h_cnt_d == '0) && (v_cnt_d == '0);
        hs_d  = in_sync(live_h_d, h_cnt_d) ? pol_d[1] : ~pol_d[1];
        vs_d  = in_sync(live_v_d, v_cnt_d) ? pol_d[0] : ~pol_d[0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started_q <= 1'b0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            live_h_q  <= H_DEF;
            live_v_q  <= V_DEF;
            pol_q     <= {HS_POL, VS_POL};
            sh_q      <= SH_EMPTY;
            sh_h_q    <= '0;
            sh_v_q    <= '0;
            sh_pol_q  <= '0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            ven_q     <= 1'b0;
            ls_q      <= 1'b0;
            fs_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            started_q <= started_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            live_h_q  <= live_h_d;
            live_v_q  <= live_v_d;
            pol_q     <= pol_d;
            sh_q      <= sh_d;
            sh_h_q    <= sh_h_d;
            sh_v_q    <= sh_v_d;
            sh_pol_q  <= sh_pol_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            ven_q     <= ven_d;
            ls_q      <= ls_d;
            fs_q      <= fs_d;
            err_q     <= err_d;
        end
    end

    assign vga.cfg_ready    = (sh_q == SH_EMPTY);
    assign vga.cfg_err      = err_q;
    assign vga.h_sync       = hs_q;
    assign vga.v_sync       = vs_q;
    assign vga.x_idx        = h_cnt_q;
    assign vga.y_idx        = v_cnt_q;
    assign vga.video_enable = ven_q;
    assign vga.line_start   = ls_q;
    assign vga.frame_start  = fs_q;

endmodule
